montgomery_iter_ctrl: RTL and testbench

//  Bit-serial Montgomery multiplier sequencer: computes result = a*b*2^-N mod m.

---
 rtl/montgomery_iter_ctrl_pkg.sv | 23 ++
 rtl/montgomery_iter_ctrl_chk.sv | 19 +
 rtl/montgomery_iter_ctrl.sv | 136 +++++++++++++
 tb/tb_montgomery_iter_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_iter_ctrl_pkg.sv
// Shared definitions for the bit-serial Montgomery sequencer: default widths
// and the 4-bit FSM state encoding.
package montgomery_iter_ctrl_pkg;

  localparam int DEF_N  = 1024;  // modulus / operand width
  localparam int DEF_AW = 1027;  // adder operand width, at least N+2
  localparam int DEF_IW = 11;    // bit-index counter width

  // Sequencer states; encodings are fixed so debug traces stay comparable.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_ADD_B  = 4'd2,
    ST_WAIT_B = 4'd3,
    ST_ADD_M  = 4'd4,
    ST_WAIT_M = 4'd5,
    ST_SHIFT  = 4'd6,
    ST_SUB    = 4'd7,
    ST_WAIT_S = 4'd8,
    ST_DONE   = 4'd9
  } mstate_e;

endpackage

// File: rtl/montgomery_iter_ctrl_chk.sv
// Property checker for the Montgomery sequencer's adder handshake and done pulse.
module montgomery_iter_ctrl_chk (
  input logic clk,
  input logic resetn,
  input logic add_done,
  input logic add_subtract,
  input logic addCarry,
  input logic done
);

  // An addition in the main loop must never carry out of the AW-bit accumulator.
  noAddCarry: assert property (@(posedge clk) disable iff (!resetn)
    (add_done && !add_subtract) |-> !addCarry);

  // done is a single-cycle pulse.
  donePulse: assert property (@(posedge clk) disable iff (!resetn)
    done |=> !done);

endmodule

// File: rtl/montgomery_iter_ctrl.sv
// Bit-serial Montgomery multiplier sequencer: result = a*b*2^-N mod m.
// Scans a LSB first; each step optionally adds b, then adds m when the
// accumulator is odd, then halves it. A final trial subtraction of m
// reduces the accumulator from [0,2m) into [0,m). The multi-precision adder
// lives in the parent; this block only drives its operands and waits for done.
module montgomery_iter_ctrl
  import montgomery_iter_ctrl_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          add_start,
  output logic          add_subtract,
  output logic [AW-1:0] add_in_a,
  output logic [AW-1:0] add_in_b,
  input  logic [AW:0]   add_result,
  input  logic          add_done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  mstate_e       state_r;
  logic [AW-1:0] accC_r;    // running accumulator, kept below 2m after each shift
  logic [N-1:0]  opA_r;     // multiplier, shifted right so bit 0 is the current bit
  logic [N-1:0]  opB_r;     // multiplicand
  logic [N-1:0]  opM_r;     // odd modulus
  logic [IW-1:0] bitIdx_r;  // index of the multiplier bit being processed

  // Sequencer FSM with datapath; every output is driven from a register here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      result       <= '0;
      done         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
      accC_r       <= '0;
      opA_r        <= '0;
      opB_r        <= '0;
      opM_r        <= '0;
      bitIdx_r     <= '0;
    end else begin
      add_start <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            opA_r    <= in_a;
            opB_r    <= in_b;
            opM_r    <= in_m;
            accC_r   <= '0;
            bitIdx_r <= '0;
            state_r  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // a zero bit with an even accumulator needs no adder call at all
          if (opA_r[0]) begin
            state_r <= ST_ADD_B;
          end else if (accC_r[0]) begin
            state_r <= ST_ADD_M;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_ADD_B: begin
          add_start    <= 1'b1;
          add_subtract <= 1'b0;
          add_in_a     <= accC_r;
          add_in_b     <= {{(AW-N){1'b0}}, opB_r};
          state_r      <= ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (add_done) begin
            accC_r  <= add_result[AW-1:0];
            // parity of the fresh sum decides whether m must be added
            state_r <= add_result[0] ? ST_ADD_M : ST_SHIFT;
          end
        end
        ST_ADD_M: begin
          add_start    <= 1'b1;
          add_subtract <= 1'b0;
          add_in_a     <= accC_r;
          add_in_b     <= {{(AW-N){1'b0}}, opM_r};
          state_r      <= ST_WAIT_M;
        end
        ST_WAIT_M: begin
          if (add_done) begin
            accC_r  <= add_result[AW-1:0];
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          accC_r   <= {1'b0, accC_r[AW-1:1]};
          opA_r    <= {1'b0, opA_r[N-1:1]};
          bitIdx_r <= bitIdx_r + 1'b1;
          state_r  <= (bitIdx_r == LAST_IDX) ? ST_SUB : ST_LOAD;
        end
        ST_SUB: begin
          add_start    <= 1'b1;
          add_subtract <= 1'b1;
          add_in_a     <= accC_r;
          add_in_b     <= {{(AW-N){1'b0}}, opM_r};
          state_r      <= ST_WAIT_S;
        end
        ST_WAIT_S: begin
          if (add_done) begin
            add_subtract <= 1'b0;
            // no borrow means C >= m, so the difference is the reduced value
            result       <= add_result[AW] ? add_result[N-1:0] : accC_r[N-1:0];
            done         <= 1'b1;
            state_r      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_iter_ctrl.sv
// Scoreboard bench for montgomery_iter_ctrl with a behavioural adder sibling.
module tb_montgomery_iter_ctrl;

  localparam int N      = 32;
  localparam int AW     = 35;
  localparam int IW     = 6;
  localparam int MAXCYC = 4000;

  typedef struct {
    logic [N-1:0] res;
    int           cnt;  // expected add_start pulses, -1 when not checked
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  inA = '0;
  logic [N-1:0]  inB = '0;
  logic [N-1:0]  inM = '0;
  logic [N-1:0]  result;
  logic          done;
  logic          add_start;
  logic          add_subtract;
  logic [AW-1:0] add_in_a;
  logic [AW-1:0] add_in_b;
  logic [AW:0]   add_result = '0;
  logic          add_done = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   doneCnt = 0;
  int   addCnt = 0;
  exp_t expQ[$];

  // adder model state
  logic          pend = 1'b0;
  int            lat = 0;
  logic [AW-1:0] latA = '0;
  logic [AW-1:0] latB = '0;
  logic          latSub = 1'b0;

  montgomery_iter_ctrl #(.N(N), .AW(AW), .IW(IW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(inA), .in_b(inB), .in_m(inM),
    .result(result), .done(done),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  montgomery_iter_ctrl_chk u_chk (
    .clk(clk), .resetn(resetn), .add_done(add_done),
    .add_subtract(add_subtract), .addCarry(add_result[AW]), .done(done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // a*b*2^-N mod m by repeated modular halving
  function automatic logic [N-1:0] montRef(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m);
    logic [63:0] x;
    x = (64'(a) * 64'(b)) % 64'(m);
    for (int k = 0; k < N; k++) begin
      if (x[0]) x = (x + 64'(m)) >> 1;
      else      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  // behavioural multi-precision adder with random latency
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend       <= 1'b0;
      add_done   <= 1'b0;
      add_result <= '0;
    end else begin
      add_done <= 1'b0;
      if (add_start) begin
        pend   <= 1'b1;
        lat    <= int'($urandom_range(0, 2));
        latA   <= add_in_a;
        latB   <= add_in_b;
        latSub <= add_subtract;
        if (!add_subtract)                add_result <= {1'b0, add_in_a} + {1'b0, add_in_b};
        else if (add_in_a >= add_in_b)    add_result <= {1'b1, add_in_a - add_in_b};
        else                              add_result <= {1'b0, add_in_a - add_in_b};
      end else if (pend) begin
        if (lat == 0) begin
          add_done <= 1'b1;
          pend     <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // operands must stay put while the adder is busy
  initial forever begin
    @(negedge clk);
    if (resetn && pend) begin
      check("hold_in_a", 64'(add_in_a), 64'(latA));
      check("hold_in_b", 64'(add_in_b), 64'(latB));
      check("hold_sub", 64'(add_subtract), 64'(latSub));
    end
  end

  // scoreboard monitor: pops an expectation on every done pulse
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!resetn) begin
      addCnt = 0;
    end else begin
      if (add_start) addCnt++;
      if (done) begin
        doneCnt++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %h expected no done", result);
        end else begin
          e = expQ.pop_front();
          check("result", 64'(result), 64'(e.res));
          if (e.cnt >= 0) check("add_start_count", 64'(addCnt), 64'(e.cnt));
        end
        addCnt = 0;
      end
    end
  end

  task automatic waitDone(input int d0);
    int c;
    c = 0;
    while (doneCnt == d0 && c < MAXCYC) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (doneCnt == d0) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", c);
    end
  endtask

  task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] m, input int cnt);
    exp_t e;
    int   d0;
    e.res = montRef(a, b, m);
    e.cnt = cnt;
    expQ.push_back(e);
    d0 = doneCnt;
    inA = a; inB = b; inM = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(d0);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_add_start"}, 64'(add_start), 64'd0);
    check({tag, "_add_subtract"}, 64'(add_subtract), 64'd0);
    check({tag, "_add_in_a"}, 64'(add_in_a), 64'd0);
    check({tag, "_add_in_b"}, 64'(add_in_b), 64'd0);
  endtask

  initial begin
    logic [N-1:0] m, a, b, expRes;
    int c, d0;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // directed cases
    runOp(32'd1, 32'd1, 32'hFFFF_FFFF, 3);
    runOp(32'd0, 32'd5, 32'd13, 1);
    m = 32'h8000_0001;
    runOp(m - 32'd1, m - 32'd1, m, -1);
    runOp(m - 32'd1, 32'd0, m, 2);

    // start pulses during WAIT_B and in the DONE cycle must be ignored
    m = $urandom | 32'h1;
    if (m < 32'd3) m = 32'd3;
    a = ($urandom % m) | 32'h1;
    if (a >= m) a = 32'd1;
    b = $urandom % m;
    expRes = montRef(a, b, m);
    expQ.push_back('{res: expRes, cnt: -1});
    d0 = doneCnt;
    inA = a; inB = b; inM = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!(add_start && !add_subtract) && c < MAXCYC) begin @(negedge clk); c++; end
    inA = $urandom; inB = $urandom; inM = $urandom | 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done && c < MAXCYC) begin @(negedge clk); c++; end
    inA = $urandom; inB = $urandom; inM = $urandom | 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("ignored_start_done_count", 64'(doneCnt - d0), 64'd1);
    check("ignored_start_result_held", 64'(result), 64'(expRes));
    check("ignored_start_queue_empty", 64'(expQ.size()), 64'd0);

    // reset while waiting for the modulus addition
    expQ.push_back('{res: montRef(32'd1, 32'd1, 32'd1001), cnt: -1});
    inA = 32'd1; inB = 32'd1; inM = 32'd1001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!(add_start && !add_subtract && add_in_b == AW'(32'd1001)) && c < MAXCYC) begin
      @(negedge clk);
      c++;
    end
    check("reached_wait_m", 64'(add_start && !add_subtract), 64'd1);
    resetn = 1'b0;
    expQ.delete();
    #1;
    checkResetOutputs("midop_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    runOp(32'h1234_5677 % 32'hF00D_0001, 32'h0BAD_CAFE, 32'hF00D_0001, -1);

    // random operands against the reference model
    for (int t = 0; t < 200; t++) begin
      if (t % 2 == 0) m = $urandom | 32'h1;
      else            m = 32'($urandom_range(3, 1000)) | 32'h1;
      if (m < 32'd3) m = 32'd3;
      a = $urandom % m;
      b = $urandom % m;
      runOp(a, b, m, -1);
    end

    check("final_queue_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
